// File: rtl/note_lane_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_lane_scheduler_if                                                     |
// | Spawn, press, selector, sprite-record and event signals of the scheduler.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface note_lane_scheduler_if #(
    parameter int NUM_SLOTS = 8
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    logic              frame_tick;
    logic              note_valid;
    logic [2:0]        note_key;
    logic              note_ready;
    logic              press_valid;
    logic [2:0]        press_key;
    logic [2:0]        sel_key;
    logic [9:0]        sel_y;
    logic              obj_valid;
    logic [SLOT_W-1:0] obj_slot;
    logic [2:0]        obj_key;
    logic [10:0]       obj_x;
    logic [9:0]        obj_y;
    logic              frame_done;
    logic              hit_pulse;
    logic [SLOT_W-1:0] hit_slot;
    logic              wrong_pulse;
    logic              miss_pulse;
    logic [2:0]        miss_key;
    logic              frame_overrun;

    modport slave (
        input  frame_tick, note_valid, note_key, press_valid, press_key, sel_y,
        output note_ready, sel_key, obj_valid, obj_slot, obj_key, obj_x, obj_y,
               frame_done, hit_pulse, hit_slot, wrong_pulse, miss_pulse, miss_key,
               frame_overrun
    );

    modport master (
        output frame_tick, note_valid, note_key, press_valid, press_key, sel_y,
        input  note_ready, sel_key, obj_valid, obj_slot, obj_key, obj_x, obj_y,
               frame_done, hit_pulse, hit_slot, wrong_pulse, miss_pulse, miss_key,
               frame_overrun
    );
endinterface
`default_nettype wire

// File: rtl/note_lane_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_lane_scheduler                                                        |
// | Holds falling notes, scrolls them per frame, emits sprite records and      |
// | resolves key presses into hit / wrong / miss events.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module note_lane_scheduler #(
    parameter int NUM_SLOTS = 8,
    parameter int X_START   = 600,
    parameter int SPEED     = 4,
    parameter int HIT_X     = 64,
    parameter int HIT_WIN   = 8
) (
    input  wire logic             clk_in,
    input  wire logic             rst_in,
    note_lane_scheduler_if.slave  bus
);
    localparam int                 SLOT_W     = $clog2(NUM_SLOTS);
    localparam logic [SLOT_W-1:0]  C_LAST_IDX = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [10:0]        C_X_START  = 11'(X_START);
    localparam logic [10:0]        C_SPEED    = 11'(SPEED);
    localparam logic signed [11:0] C_HIT_X    = 12'(HIT_X);
    localparam logic signed [11:0] C_HIT_WIN  = 12'(HIT_WIN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_SLOTS-1:0] r_active;
    logic [10:0]         r_x   [NUM_SLOTS];
    logic [2:0]          r_key [NUM_SLOTS];
    logic [SLOT_W-1:0]   r_idx;
    logic                r_pend_valid;
    logic [2:0]          r_pend_key;

    logic                r_obj_valid;
    logic [SLOT_W-1:0]   r_obj_slot;
    logic [2:0]          r_obj_key;
    logic [10:0]         r_obj_x;
    logic [9:0]          r_obj_y;
    logic                r_hit_pulse;
    logic [SLOT_W-1:0]   r_hit_slot;
    logic                r_wrong_pulse;
    logic                r_miss_pulse;
    logic [2:0]          r_miss_key;
    logic                r_frame_overrun;

    logic                w_note_ready;
    logic                w_frame_done;
    logic [2:0]          w_sel_key;
    logic                w_any_free;
    logic [SLOT_W-1:0]   w_free_idx;
    logic                w_resolve;
    logic [2:0]          w_res_key;
    logic                w_hit_found;
    logic [SLOT_W-1:0]   w_hit_idx;
    logic signed [11:0]  w_dist;
    logic signed [11:0]  w_abs;

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_note_ready = 1'b0;
        w_frame_done = 1'b0;
        w_sel_key    = 3'd0;
        case (r_state)
            ST_IDLE: begin
                w_note_ready = w_any_free && !bus.frame_tick && !rst_in;
                if (bus.frame_tick) w_state_next = ST_SCAN;
            end
            ST_SCAN: begin
                w_sel_key = r_key[r_idx];
                if (r_idx == C_LAST_IDX) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                w_frame_done = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Lowest-index free slot and lowest-index hittable slot, both on start-of-cycle state.
    always_comb begin
        w_any_free  = 1'b0;
        w_free_idx  = '0;
        w_hit_found = 1'b0;
        w_hit_idx   = '0;
        w_dist      = '0;
        w_abs       = '0;
        w_res_key   = r_pend_valid ? r_pend_key : bus.press_key;
        w_resolve   = (r_state == ST_IDLE) && (r_pend_valid || bus.press_valid);
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            w_dist = $signed({1'b0, r_x[i]}) - C_HIT_X;
            w_abs  = w_dist[11] ? -w_dist : w_dist;
            if (!r_active[i]) begin
                w_any_free = 1'b1;
                w_free_idx = SLOT_W'(i);
            end
            if (r_active[i] && (r_key[i] == w_res_key) && (w_abs <= C_HIT_WIN)) begin
                w_hit_found = 1'b1;
                w_hit_idx   = SLOT_W'(i);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_active        <= '0;
            r_idx           <= '0;
            r_pend_valid    <= 1'b0;
            r_pend_key      <= 3'd0;
            r_obj_valid     <= 1'b0;
            r_obj_slot      <= '0;
            r_obj_key       <= 3'd0;
            r_obj_x         <= 11'd0;
            r_obj_y         <= 10'd0;
            r_hit_pulse     <= 1'b0;
            r_hit_slot      <= '0;
            r_wrong_pulse   <= 1'b0;
            r_miss_pulse    <= 1'b0;
            r_miss_key      <= 3'd0;
            r_frame_overrun <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_x[i]   <= 11'd0;
                r_key[i] <= 3'd0;
            end
        end else begin
            r_obj_valid     <= 1'b0;
            r_hit_pulse     <= 1'b0;
            r_wrong_pulse   <= 1'b0;
            r_miss_pulse    <= 1'b0;
            r_frame_overrun <= bus.frame_tick && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    r_idx <= '0;
                    if (w_resolve) begin
                        if (w_hit_found) begin
                            r_active[w_hit_idx] <= 1'b0;
                            r_hit_pulse         <= 1'b1;
                            r_hit_slot          <= w_hit_idx;
                        end else begin
                            r_wrong_pulse <= 1'b1;
                        end
                    end
                    // A pending press is served first; a fresh press queues behind it.
                    if (r_pend_valid) begin
                        r_pend_valid <= bus.press_valid;
                        if (bus.press_valid) r_pend_key <= bus.press_key;
                    end
                    if (bus.note_valid && w_note_ready) begin
                        r_active[w_free_idx] <= 1'b1;
                        r_x[w_free_idx]      <= C_X_START;
                        r_key[w_free_idx]    <= bus.note_key;
                    end
                end
                ST_SCAN: begin
                    r_idx      <= r_idx + SLOT_W'(1);
                    r_obj_slot <= r_idx;
                    r_obj_key  <= r_key[r_idx];
                    r_obj_y    <= bus.sel_y;
                    r_obj_x    <= r_x[r_idx] - C_SPEED;
                    if (r_active[r_idx]) begin
                        if (r_x[r_idx] < C_SPEED) begin
                            r_active[r_idx] <= 1'b0;
                            r_miss_pulse    <= 1'b1;
                            r_miss_key      <= r_key[r_idx];
                        end else begin
                            r_x[r_idx]  <= r_x[r_idx] - C_SPEED;
                            r_obj_valid <= 1'b1;
                        end
                    end
                    if (bus.press_valid) begin
                        r_pend_valid <= 1'b1;
                        r_pend_key   <= bus.press_key;
                    end
                end
                default: begin
                    if (bus.press_valid) begin
                        r_pend_valid <= 1'b1;
                        r_pend_key   <= bus.press_key;
                    end
                end
            endcase
        end
    end

    assign bus.note_ready    = w_note_ready;
    assign bus.sel_key       = w_sel_key;
    assign bus.frame_done    = w_frame_done;
    assign bus.obj_valid     = r_obj_valid;
    assign bus.obj_slot      = r_obj_slot;
    assign bus.obj_key       = r_obj_key;
    assign bus.obj_x         = r_obj_x;
    assign bus.obj_y         = r_obj_y;
    assign bus.hit_pulse     = r_hit_pulse;
    assign bus.hit_slot      = r_hit_slot;
    assign bus.wrong_pulse   = r_wrong_pulse;
    assign bus.miss_pulse    = r_miss_pulse;
    assign bus.miss_key      = r_miss_key;
    assign bus.frame_overrun = r_frame_overrun;
endmodule
`default_nettype wire

// File: tb/tb_note_lane_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_note_lane_scheduler                                                     |
// | Directed and randomized bench with a frame-level reference model.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_note_lane_scheduler;
    localparam int N     = 8;
    localparam int SPEED = 4;
    localparam int XS    = 600;
    localparam int HX    = 64;
    localparam int HW    = 8;

    logic clk_in  = 1'b0;
    logic rst_in  = 1'b1;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    note_lane_scheduler_if #(.NUM_SLOTS(N)) bus ();

    // location_selector stand-in: y = 50 + 120*key
    assign bus.sel_y = 10'(50 + 120 * int'(bus.sel_key));

    note_lane_scheduler #(
        .NUM_SLOTS(N), .X_START(XS), .SPEED(SPEED), .HIT_X(HX), .HIT_WIN(HW)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct packed {
        bit obj_v; int slot; int key; int x; int y;
        bit fd; bit miss; int miss_key;
        bit hit; int hit_slot; bit wrong; bit ovr;
        bit sel_chk; int sel_key;
    } exp_t;

    exp_t ring [32];
    bit   m_act [N];
    int   m_x   [N];
    int   m_key [N];
    bit   m_pend = 1'b0;
    int   m_pkey = 0;
    int   m_busy_until = 0;
    bit   m_live = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: a tick commits the whole frame's outcome and schedules its outputs.
    always @(negedge clk_in) begin : p_model
        exp_t e;
        int   c, fidx, hit_i, rkey, d, r;
        bit   idle, any_free, do_res;
        c = cyc;
        e = ring[c % 32];
        ring[c % 32] = '0;
        idle = (c >= m_busy_until);
        any_free = 1'b0;
        fidx = 0;
        for (int i = N - 1; i >= 0; i--)
            if (!m_act[i]) begin any_free = 1'b1; fidx = i; end

        if (m_live) begin
            chk("note_ready", bus.note_ready, idle && any_free && !bus.frame_tick && !rst_in);
            if (e.sel_chk) chk("sel_key", bus.sel_key, e.sel_key);
            chk("obj_valid", bus.obj_valid, e.obj_v);
            if (e.obj_v) begin
                chk("obj_slot", bus.obj_slot, e.slot);
                chk("obj_key", bus.obj_key, e.key);
                chk("obj_x", bus.obj_x, e.x);
                chk("obj_y", bus.obj_y, e.y);
            end
            chk("frame_done", bus.frame_done, e.fd);
            chk("miss_pulse", bus.miss_pulse, e.miss);
            if (e.miss) chk("miss_key", bus.miss_key, e.miss_key);
            chk("hit_pulse", bus.hit_pulse, e.hit);
            if (e.hit) chk("hit_slot", bus.hit_slot, e.hit_slot);
            chk("wrong_pulse", bus.wrong_pulse, e.wrong);
            chk("frame_overrun", bus.frame_overrun, e.ovr);
        end

        if (rst_in) begin
            m_live = 1'b1;
            m_pend = 1'b0;
            m_busy_until = 0;
            for (int i = 0; i < N; i++) begin m_act[i] = 1'b0; m_x[i] = 0; m_key[i] = 0; end
            for (int j = 0; j < 32; j++) ring[j] = '0;
        end else if (m_live) begin
            ring[(c + 1) % 32].ovr = bus.frame_tick && !idle;
            if (idle) begin
                do_res = m_pend || bus.press_valid;
                rkey   = m_pend ? m_pkey : int'(bus.press_key);
                hit_i  = -1;
                if (do_res)
                    for (int i = N - 1; i >= 0; i--) begin
                        d = m_x[i] - HX;
                        if (d < 0) d = -d;
                        if (m_act[i] && m_key[i] == rkey && d <= HW) hit_i = i;
                    end
                if (m_pend) begin
                    m_pend = bus.press_valid;
                    if (bus.press_valid) m_pkey = int'(bus.press_key);
                end
                if (bus.note_valid && any_free && !bus.frame_tick) begin
                    m_act[fidx] = 1'b1;
                    m_x[fidx]   = XS;
                    m_key[fidx] = int'(bus.note_key);
                end
                if (do_res) begin
                    if (hit_i >= 0) begin
                        m_act[hit_i] = 1'b0;
                        ring[(c + 1) % 32].hit = 1'b1;
                        ring[(c + 1) % 32].hit_slot = hit_i;
                    end else begin
                        ring[(c + 1) % 32].wrong = 1'b1;
                    end
                end
                if (bus.frame_tick) begin
                    m_busy_until = c + N + 2;
                    ring[(c + N + 1) % 32].fd = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        r = (c + 2 + i) % 32;
                        if (m_act[i]) begin
                            ring[(c + 1 + i) % 32].sel_chk = 1'b1;
                            ring[(c + 1 + i) % 32].sel_key = m_key[i];
                            if (m_x[i] < SPEED) begin
                                m_act[i] = 1'b0;
                                ring[r].miss = 1'b1;
                                ring[r].miss_key = m_key[i];
                            end else begin
                                m_x[i] = m_x[i] - SPEED;
                                ring[r].obj_v = 1'b1;
                                ring[r].slot  = i;
                                ring[r].key   = m_key[i];
                                ring[r].x     = m_x[i];
                                ring[r].y     = 50 + 120 * m_key[i];
                            end
                        end
                    end
                end
            end else if (bus.press_valid) begin
                m_pend = 1'b1;
                m_pkey = int'(bus.press_key);
            end
        end
    end

    task automatic nxt();
        @(posedge clk_in);
        #1;
        bus.frame_tick  = 1'b0;
        bus.note_valid  = 1'b0;
        bus.press_valid = 1'b0;
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        repeat (N + 2) nxt();
    endtask

    initial begin
        bus.frame_tick  = 1'b0;
        bus.note_valid  = 1'b0;
        bus.note_key    = 3'd0;
        bus.press_valid = 1'b0;
        bus.press_key   = 3'd0;
        rst_in = 1'b1;
        repeat (3) nxt();
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst_note_ready", bus.note_ready, 1);
        chk("rst_obj_valid", bus.obj_valid, 0);
        chk("rst_sel_key", bus.sel_key, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        nxt();
        bus.note_valid = 1'b1;
        bus.note_key   = 3'd3;
        nxt();
        bus.frame_tick = 1'b1;
        repeat (2) nxt();
        @(negedge clk_in);
        chk("first_obj_valid", bus.obj_valid, 1);
        chk("first_obj_slot", bus.obj_slot, 0);
        chk("first_obj_key", bus.obj_key, 3);
        chk("first_obj_x", bus.obj_x, 596);
        chk("first_obj_y", bus.obj_y, 410);
        repeat (7) nxt();
        @(negedge clk_in);
        chk("first_frame_done", bus.frame_done, 1);
        nxt();

        // fill all slots, then hold a ninth request
        rst_in = 1'b1;
        nxt();
        rst_in = 1'b0;
        for (int k = 0; k < N; k++) begin
            bus.note_valid = 1'b1;
            bus.note_key   = 3'(k);
            nxt();
        end
        bus.note_valid = 1'b1;
        bus.note_key   = 3'd7;
        @(negedge clk_in);
        chk("full_note_ready", bus.note_ready, 0);
        nxt();
        bus.note_valid = 1'b1;
        nxt();

        // 134 frames bring every note to x=64
        repeat (134) frame();
        bus.press_valid = 1'b1;
        bus.press_key   = 3'd3;
        nxt();
        @(negedge clk_in);
        chk("hit_pulse_x64", bus.hit_pulse, 1);
        chk("hit_slot_x64", bus.hit_slot, 3);
        nxt();
        bus.note_valid = 1'b1;
        bus.note_key   = 3'd6;
        nxt();
        bus.press_valid = 1'b1;
        bus.press_key   = 3'd3;
        nxt();
        @(negedge clk_in);
        chk("wrong_pulse", bus.wrong_pulse, 1);
        nxt();

        // overrun tick and a pending press resolved after the frame
        bus.frame_tick = 1'b1;
        repeat (3) nxt();
        bus.frame_tick = 1'b1;
        nxt();
        bus.press_valid = 1'b1;
        bus.press_key   = 3'd2;
        @(negedge clk_in);
        chk("frame_overrun", bus.frame_overrun, 1);
        repeat (7) nxt();
        @(negedge clk_in);
        chk("pending_hit_pulse", bus.hit_pulse, 1);
        chk("pending_hit_slot", bus.hit_slot, 2);
        nxt();

        // x=60 -> 0 after 15 frames; next frame misses
        repeat (15) frame();
        bus.frame_tick = 1'b1;
        repeat (2) nxt();
        @(negedge clk_in);
        chk("miss_pulse_s0", bus.miss_pulse, 1);
        chk("miss_key_s0", bus.miss_key, 0);
        repeat (5) nxt();
        @(negedge clk_in);
        chk("miss_pulse_s5", bus.miss_pulse, 1);
        chk("miss_key_s5", bus.miss_key, 5);
        repeat (3) nxt();

        // reset mid-scan
        bus.frame_tick = 1'b1;
        repeat (4) nxt();
        rst_in = 1'b1;
        nxt();
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("midrst_obj_valid", bus.obj_valid, 0);
        chk("midrst_frame_done", bus.frame_done, 0);
        chk("midrst_note_ready", bus.note_ready, 1);
        nxt();

        for (int i = 0; i < 5000; i++) begin
            bus.frame_tick  = ($urandom_range(0, 9) == 0);
            bus.note_valid  = ($urandom_range(0, 3) == 0);
            bus.note_key    = 3'($urandom_range(0, 7));
            bus.press_valid = ($urandom_range(0, 2) == 0);
            bus.press_key   = 3'($urandom_range(0, 7));
            rst_in          = ($urandom_range(0, 2499) == 0);
            nxt();
        end
        rst_in = 1'b0;
        repeat (12) nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
